// File: rtl/data_cache_pkg.sv
// Shared types and widths for the direct-mapped write-through data cache.
// Address geometry is derived from the number of sets.
package data_cache_pkg;

  localparam int ADDR_W              = 15;
  localparam int WORD_W              = 32;
  localparam int BLOCK_W             = 4 * WORD_W;
  localparam int OFFSET_W            = 2;
  localparam int CNT_W               = 16;
  localparam int LAT_W               = 4;
  localparam int DEFAULT_SETS        = 64;
  localparam int DEFAULT_MEM_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE,
    MISS_WAIT,
    FILL
  } state_t;

  function automatic int index_width(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_width(input int sets);
    return ADDR_W - OFFSET_W - $clog2(sets);
  endfunction

endpackage

// File: rtl/data_cache_store.sv
// Tag, valid and data arrays for the data cache: one combinational read
// port, plus a single-word store port and a whole-block fill port.
module cache_store
  import data_cache_pkg::*;
#(
  parameter int SETS    = DEFAULT_SETS,
  parameter int INDEX_W = index_width(SETS),
  parameter int TAG_W   = tag_width(SETS)
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_block,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic               wr_word_en,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [WORD_W-1:0]  wr_word,
  input  logic               fill_en,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0] fill_block
);

  logic [SETS-1:0]    valid_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [BLOCK_W-1:0] data_q [SETS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_block = data_q[rd_index];

  // Only the valid bits are cleared; stale tags and data are harmless once invalid.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (fill_en) begin
      tag_q[wr_index]  <= fill_tag;
      data_q[wr_index] <= fill_block;
    end else if (wr_word_en) begin
      data_q[wr_index][{wr_offset, 5'b00000} +: WORD_W] <= wr_word;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a
// fixed-latency block refill and saturating read hit/miss statistics.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int SETS        = DEFAULT_SETS,
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               cpuRead,
  input  logic               cpuWrite,
  input  logic [ADDR_W-1:0]  cpuAddress,
  input  logic [WORD_W-1:0]  cpuDataIn,
  output logic [WORD_W-1:0]  cpuDataOut,
  output logic               stall,
  output logic [ADDR_W-1:0]  memAddress,
  output logic               memWrite,
  output logic [WORD_W-1:0]  memDataOut,
  input  logic [BLOCK_W-1:0] memDataIn,
  output logic [CNT_W-1:0]   hitCount,
  output logic [CNT_W-1:0]   missCount
);

  localparam int INDEX_W = index_width(SETS);
  localparam int TAG_W   = tag_width(SETS);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [OFFSET_W-1:0] offset;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic [ADDR_W-1:0]   block_addr;

  assign offset     = cpuAddress[OFFSET_W-1:0];
  assign index      = cpuAddress[OFFSET_W +: INDEX_W];
  assign tag        = cpuAddress[ADDR_W-1 -: TAG_W];
  assign block_addr = {cpuAddress[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [BLOCK_W-1:0] line_block;
  logic               hit;

  state_t           state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] hit_q, miss_q;
  logic             replay_q;
  logic             read_hit, read_miss, fill_en, wr_word_en;

  assign hit        = line_valid && (line_tag == tag);
  assign cpuDataOut = line_block[{offset, 5'b00000} +: WORD_W];
  assign hitCount   = hit_q;
  assign missCount  = miss_q;

  cache_store #(
    .SETS    (SETS),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_store (
    .clock      (clock),
    .resetN     (resetN),
    .rd_index   (index),
    .rd_valid   (line_valid),
    .rd_tag     (line_tag),
    .rd_block   (line_block),
    .wr_index   (index),
    .wr_word_en (wr_word_en & resetN),
    .wr_offset  (offset),
    .wr_word    (cpuDataIn),
    .fill_en    (fill_en & resetN),
    .fill_tag   (tag),
    .fill_block (memDataIn)
  );

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    stall      = 1'b0;
    memAddress = cpuAddress;
    memWrite   = 1'b0;
    memDataOut = cpuDataIn;
    fill_en    = 1'b0;
    wr_word_en = 1'b0;
    read_hit   = 1'b0;
    read_miss  = 1'b0;
    case (state_q)
      IDLE: begin
        // A store wins over a simultaneous load; the load is dropped.
        if (cpuWrite) begin
          memWrite   = 1'b1;
          wr_word_en = hit;
        end else if (cpuRead) begin
          if (hit) begin
            read_hit = 1'b1;
          end else begin
            read_miss  = 1'b1;
            stall      = 1'b1;
            memAddress = block_addr;
            lat_d      = LAT_W'(MEM_LATENCY - 1);
            state_d    = (MEM_LATENCY <= 1) ? FILL : MISS_WAIT;
          end
        end
      end
      MISS_WAIT: begin
        stall      = 1'b1;
        memAddress = block_addr;
        lat_d      = lat_q - LAT_W'(1);
        if (lat_q <= LAT_W'(1)) begin
          state_d = FILL;
        end
      end
      FILL: begin
        stall      = 1'b1;
        memAddress = block_addr;
        fill_en    = 1'b1;
        lat_d      = '0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        lat_d   = '0;
      end
    endcase
  end

  // The first hit after a fill completes the missed load and is not a new hit.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      replay_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      replay_q <= (state_q == FILL);
      if (read_hit && !replay_q) begin
        hit_q <= sat_inc(hit_q);
      end
      if (read_miss) begin
        miss_q <= sat_inc(miss_q);
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: backing memory returns word a as a+100
// unless the cache has written it through.
module tb_data_cache;

  logic         clock;
  logic         resetN;
  logic         cpuRead;
  logic         cpuWrite;
  logic [14:0]  cpuAddress;
  logic [31:0]  cpuDataIn;
  logic [31:0]  cpuDataOut;
  logic         stall;
  logic [14:0]  memAddress;
  logic         memWrite;
  logic [31:0]  memDataOut;
  logic [127:0] memDataIn;
  logic [15:0]  hitCount;
  logic [15:0]  missCount;

  int checks = 0;
  int errors = 0;

  data_cache #(.SETS(64), .MEM_LATENCY(4)) dut (
    .clock      (clock),
    .resetN     (resetN),
    .cpuRead    (cpuRead),
    .cpuWrite   (cpuWrite),
    .cpuAddress (cpuAddress),
    .cpuDataIn  (cpuDataIn),
    .cpuDataOut (cpuDataOut),
    .stall      (stall),
    .memAddress (memAddress),
    .memWrite   (memWrite),
    .memDataOut (memDataOut),
    .memDataIn  (memDataIn),
    .hitCount   (hitCount),
    .missCount  (missCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  bit [31:0] ovr   [32768];
  bit        ovr_v [32768];

  function automatic logic [31:0] memword(input logic [14:0] a);
    return ovr_v[a] ? ovr[a] : ({17'b0, a} + 32'd100);
  endfunction

  always_comb begin
    memDataIn = {memword({memAddress[14:2], 2'd3}), memword({memAddress[14:2], 2'd2}),
                 memword({memAddress[14:2], 2'd1}), memword({memAddress[14:2], 2'd0})};
  end

  always @(posedge clock) begin
    if (memWrite) begin
      ovr[memAddress]   <= memDataOut;
      ovr_v[memAddress] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue a load, count stalled cycles (bounded), capture data, consume the hit edge.
  task automatic do_read(input logic [14:0] a, output int n, output logic [31:0] d);
    cpuRead    = 1'b1;
    cpuAddress = a;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 30) begin
      @(posedge clock);
      #1;
      n++;
    end
    d = cpuDataOut;
    @(posedge clock);
    #1;
    cpuRead = 1'b0;
  endtask

  int          n;
  logic [31:0] d;

  initial begin
    resetN     = 1'b0;
    cpuRead    = 1'b0;
    cpuWrite   = 1'b0;
    cpuAddress = '0;
    cpuDataIn  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_hitCount", 32'(hitCount), 32'd0);
    chk("rst_missCount", 32'(missCount), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_memWrite", 32'(memWrite), 32'd0);
    resetN = 1'b1;

    do_read(15'd184, n, d);
    chk("miss184_stall_cycles", 32'(n), 32'd5);
    chk("miss184_data", d, 32'd284);
    chk("miss184_missCount", 32'(missCount), 32'd1);
    chk("miss184_hitCount", 32'(hitCount), 32'd0);

    do_read(15'd185, n, d);
    chk("hit185_stall", 32'(n), 32'd0);
    chk("hit185_data", d, 32'd285);
    do_read(15'd186, n, d);
    chk("hit186_stall", 32'(n), 32'd0);
    chk("hit186_data", d, 32'd286);
    do_read(15'd187, n, d);
    chk("hit187_stall", 32'(n), 32'd0);
    chk("hit187_data", d, 32'd287);
    chk("hits_hitCount", 32'(hitCount), 32'd3);
    chk("hits_missCount", 32'(missCount), 32'd1);

    cpuWrite   = 1'b1;
    cpuAddress = 15'd186;
    cpuDataIn  = 32'h0000_00AB;
    #1;
    chk("wr186_memWrite", 32'(memWrite), 32'd1);
    chk("wr186_memAddress", 32'(memAddress), 32'd186);
    chk("wr186_memDataOut", memDataOut, 32'h0000_00AB);
    chk("wr186_stall", 32'(stall), 32'd0);
    @(posedge clock);
    #1;
    cpuWrite = 1'b0;
    do_read(15'd186, n, d);
    chk("rd186_after_wr_stall", 32'(n), 32'd0);
    chk("rd186_after_wr_data", d, 32'h0000_00AB);
    chk("rd186_hitCount", 32'(hitCount), 32'd4);

    cpuWrite   = 1'b1;
    cpuAddress = 15'd440;
    cpuDataIn  = 32'h0000_0077;
    #1;
    chk("wrmiss440_memWrite", 32'(memWrite), 32'd1);
    chk("wrmiss440_stall", 32'(stall), 32'd0);
    @(posedge clock);
    #1;
    cpuWrite = 1'b0;
    chk("wrmiss440_missCount", 32'(missCount), 32'd1);
    do_read(15'd184, n, d);
    chk("wrmiss_no_alloc_stall", 32'(n), 32'd0);
    chk("wrmiss_no_alloc_data", d, 32'd284);

    cpuRead    = 1'b1;
    cpuWrite   = 1'b1;
    cpuAddress = 15'd185;
    cpuDataIn  = 32'h0000_0055;
    #1;
    chk("rdwr185_memWrite", 32'(memWrite), 32'd1);
    chk("rdwr185_stall", 32'(stall), 32'd0);
    @(posedge clock);
    #1;
    cpuRead  = 1'b0;
    cpuWrite = 1'b0;
    chk("rdwr185_hitCount", 32'(hitCount), 32'd5);
    chk("rdwr185_missCount", 32'(missCount), 32'd1);
    do_read(15'd185, n, d);
    chk("rd185_after_rdwr_data", d, 32'h0000_0055);

    do_read(15'd440, n, d);
    chk("miss440_stall_cycles", 32'(n), 32'd5);
    chk("miss440_data", d, 32'h0000_0077);
    chk("miss440_missCount", 32'(missCount), 32'd2);
    do_read(15'd184, n, d);
    chk("remiss184_stall_cycles", 32'(n), 32'd5);
    chk("remiss184_data", d, 32'd284);
    chk("remiss184_missCount", 32'(missCount), 32'd3);
    chk("remiss184_hitCount", 32'(hitCount), 32'd6);

    cpuRead    = 1'b1;
    cpuAddress = 15'd442;
    #1;
    chk("miss442_idle_stall", 32'(stall), 32'd1);
    @(posedge clock);
    #1;
    chk("miss442_wait_memAddress", 32'(memAddress), 32'd440);
    chk("miss442_wait_memWrite", 32'(memWrite), 32'd0);
    @(posedge clock);
    #1;
    resetN = 1'b0;
    @(posedge clock);
    #1;
    cpuRead = 1'b0;
    resetN  = 1'b1;
    #1;
    chk("midmiss_rst_stall", 32'(stall), 32'd0);
    chk("midmiss_rst_hitCount", 32'(hitCount), 32'd0);
    chk("midmiss_rst_missCount", 32'(missCount), 32'd0);
    @(posedge clock);
    #1;
    do_read(15'd184, n, d);
    chk("postrst184_stall_cycles", 32'(n), 32'd5);
    chk("postrst184_data", d, 32'd284);
    chk("postrst184_missCount", 32'(missCount), 32'd1);
    chk("postrst184_hitCount", 32'(hitCount), 32'd0);

    cpuRead    = 1'b1;
    cpuAddress = 15'd184;
    repeat (65534) @(posedge clock);
    #1;
    chk("sat_pre_hitCount", 32'(hitCount), 32'h0000_FFFE);
    repeat (3) @(posedge clock);
    #1;
    cpuRead = 1'b0;
    chk("sat_hitCount", 32'(hitCount), 32'h0000_FFFF);
    chk("sat_missCount", 32'(missCount), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
